// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared types, default constants and address helper for the
//               mips_mem memory responder.
//               word_t            - 32-bit data/address word
//               DEFAULT_*         - default parameter values for mips_mem
//               addr_to_idx()     - BASE-relative byte address -> word index
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

  typedef logic [31:0] word_t;

  localparam word_t DEFAULT_BASE_ADDR   = 32'h8002_0000;
  localparam word_t DEFAULT_BAD_WORD    = 32'hDEAD_BEEF;
  localparam int    DEFAULT_DEPTH_WORDS = 262144;
  localparam int    DEFAULT_IDX_W       = 18;

  // Full 32-bit word offset from base. Callers range-check this before
  // truncating it to an array index; addresses below base produce a large
  // wrapped value here, so they must be rejected separately.
  function automatic word_t addr_to_idx(input word_t addr, input word_t base);
    return (addr - base) >> 2;
  endfunction

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/mips_mem_xlate.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_xlate
// Description : Combinational byte-address to word-index translation with
//               validity check (aligned, not below base, inside the array).
// Ports       : addr_i  - byte address
//               idx_o   - word index into the array (meaningful when valid_o)
//               valid_o - 1 when the address maps onto a real array word
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_xlate
  import mips_mem_pkg::*;
#(
  parameter word_t BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int    DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int    IDX_W       = DEFAULT_IDX_W
) (
  input  logic [31:0]      addr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  word_t w_word;

  assign w_word  = addr_to_idx(addr_i, BASE_ADDR);
  // The explicit lower-bound test keeps addresses below base from wrapping
  // into the top of the array.
  assign valid_o = (addr_i >= BASE_ADDR) &&
                   (w_word < word_t'(DEPTH_WORDS)) &&
                   (addr_i[1:0] == 2'b00);
  assign idx_o   = w_word[IDX_W-1:0];

endmodule : mips_mem_xlate
`default_nettype wire

// File: rtl/mips_mem.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem
// Description : Memory responder for the multi-cycle MIPS core. One word
//               array shared by a read-only fetch port and a read/write data
//               port, both with 1-cycle registered read data and write-first
//               behaviour. Includes a sequential preload streamer, sticky
//               preload-overflow flag and sticky access-error capture.
// Ports       : clk, reset (sync, active-low)
//               instr_addr / instr_in          - fetch port
//               data_addr / data_out / data_rd_wr / data_in - data port
//               load_en / load_data / load_ovf - preload streamer
//               mem_err / err_addr             - sticky fault capture
// Options     : MIPS_MEM_ACCESS_CNT_EN adds saturating counters rd_cnt,
//               wr_cnt and fetch_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem
  import mips_mem_pkg::*;
#(
  parameter word_t BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int    DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int    IDX_W       = DEFAULT_IDX_W,
  parameter word_t BAD_WORD    = DEFAULT_BAD_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_rd_wr,
  output logic [31:0] data_in,
  input  logic        load_en,
  input  logic [31:0] load_data,
  output logic        load_ovf,
  output logic        mem_err,
  output logic [31:0] err_addr
`ifdef MIPS_MEM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [31:0] fetch_cnt
`endif
);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] w_if_idx;
  logic             w_if_ok;
  logic [IDX_W-1:0] w_d_idx;
  logic             w_d_ok;

  mips_mem_xlate #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_xlate_if (
    .addr_i (instr_addr),
    .idx_o  (w_if_idx),
    .valid_o(w_if_ok)
  );

  mips_mem_xlate #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_xlate_d (
    .addr_i (data_addr),
    .idx_o  (w_d_idx),
    .valid_o(w_d_ok)
  );

  logic [31:0]      instr_in_q, instr_in_d;
  logic [31:0]      data_in_q,  data_in_d;
  logic             mem_err_q,  mem_err_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic             load_ovf_q, load_ovf_d;
  logic [IDX_W-1:0] ptr_q,      ptr_d;

  // Single shared write port. Preload wins over a core write; nothing is
  // written while reset is asserted.
  logic             w_pre_we;
  logic             w_core_we;
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  logic [31:0]      w_wdata;
  logic             w_fault;

  assign w_pre_we  = reset && load_en && !load_ovf_q;
  assign w_core_we = reset && !data_rd_wr && w_d_ok && !w_pre_we;
  assign w_we      = w_pre_we || w_core_we;
  assign w_widx    = w_pre_we ? ptr_q : w_d_idx;
  assign w_wdata   = w_pre_we ? load_data : data_out;
  assign w_fault   = !w_if_ok || !w_d_ok;

  always_comb begin
    instr_in_d = BAD_WORD;
    data_in_d  = BAD_WORD;
    mem_err_d  = mem_err_q | w_fault;
    err_addr_d = err_addr_q;
    load_ovf_d = load_ovf_q;
    ptr_d      = ptr_q;

    // Both read ports see the word as it will be after this edge's write.
    if (w_if_ok) begin
      instr_in_d = (w_we && (w_widx == w_if_idx)) ? w_wdata : mem_q[w_if_idx];
    end

    if (!data_rd_wr) begin
      data_in_d = data_out;
    end else if (w_d_ok) begin
      data_in_d = (w_we && (w_widx == w_d_idx)) ? w_wdata : mem_q[w_d_idx];
    end

    // Only the first fault is recorded; the data port takes precedence.
    if (w_fault && !mem_err_q) begin
      err_addr_d = !w_d_ok ? data_addr : instr_addr;
    end

    // The pointer parks on the last index instead of wrapping.
    if (w_pre_we) begin
      if (ptr_q == IDX_W'(DEPTH_WORDS - 1)) begin
        load_ovf_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[w_widx] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_in_q <= '0;
      data_in_q  <= '0;
      mem_err_q  <= 1'b0;
      err_addr_q <= '0;
      load_ovf_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      instr_in_q <= instr_in_d;
      data_in_q  <= data_in_d;
      mem_err_q  <= mem_err_d;
      err_addr_q <= err_addr_d;
      load_ovf_q <= load_ovf_d;
      ptr_q      <= ptr_d;
    end
  end

  assign instr_in = instr_in_q;
  assign data_in  = data_in_q;
  assign mem_err  = mem_err_q;
  assign err_addr = err_addr_q;
  assign load_ovf = load_ovf_q;

`ifdef MIPS_MEM_ACCESS_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  // Counts reflect valid requests seen on the port, independent of whether
  // preload arbitration dropped a write.
  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if (w_d_ok && data_rd_wr && (rd_cnt_q != 32'hFFFF_FFFF)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (w_d_ok && !data_rd_wr && (wr_cnt_q != 32'hFFFF_FFFF)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
    if (w_if_ok && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      fetch_cnt_q <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule : mips_mem
`default_nettype wire

// File: tb/tb_mips_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mem
// Description : Self-checking bench for mips_mem. A full-depth instance is
//               checked against a behavioural memory model; a depth-4
//               instance exercises preload overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem;

  localparam logic [31:0] BASE  = 32'h8002_0000;
  localparam logic [31:0] BAD   = 32'hDEAD_BEEF;
  localparam longint      DEPTH = 262144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // full-depth instance
  logic        reset;
  logic [31:0] instr_addr, instr_in, data_addr, data_out, data_in;
  logic        data_rd_wr, load_en, load_ovf, mem_err;
  logic [31:0] load_data, err_addr;

  // depth-4 instance
  logic        s_reset;
  logic [31:0] s_instr_addr, s_instr_in, s_data_addr, s_data_out, s_data_in;
  logic        s_data_rd_wr, s_load_en, s_load_ovf, s_mem_err;
  logic [31:0] s_load_data, s_err_addr;

  mips_mem u_dut (
    .clk       (clk),
    .reset     (reset),
    .instr_addr(instr_addr),
    .instr_in  (instr_in),
    .data_addr (data_addr),
    .data_out  (data_out),
    .data_rd_wr(data_rd_wr),
    .data_in   (data_in),
    .load_en   (load_en),
    .load_data (load_data),
    .load_ovf  (load_ovf),
    .mem_err   (mem_err),
    .err_addr  (err_addr)
  );

  mips_mem #(.DEPTH_WORDS(4), .IDX_W(2)) u_small (
    .clk       (clk),
    .reset     (s_reset),
    .instr_addr(s_instr_addr),
    .instr_in  (s_instr_in),
    .data_addr (s_data_addr),
    .data_out  (s_data_out),
    .data_rd_wr(s_data_rd_wr),
    .data_in   (s_data_in),
    .load_en   (s_load_en),
    .load_data (s_load_data),
    .load_ovf  (s_load_ovf),
    .mem_err   (s_mem_err),
    .err_addr  (s_err_addr)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model of the full-depth instance ----------
  logic [31:0] m_mem [int unsigned];
  int unsigned m_ptr;
  bit          m_ovf, m_err;
  logic [31:0] m_err_addr, e_instr, e_data;

  function automatic bit addr_ok(input logic [31:0] a);
    if (a < BASE) return 1'b0;
    if (a % 4 != 0) return 1'b0;
    return ((longint'(a) - longint'(BASE)) / 4) < DEPTH;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return (a - BASE) / 4;
  endfunction

  function automatic logic [31:0] m_read(input int unsigned i);
    if (m_mem.exists(i)) return m_mem[i];
    return 'x;
  endfunction

  // Applies one clock edge's worth of rules to the model; reads observe the
  // array contents after that edge's write.
  task automatic model_edge();
    bit iok, dok, pre;
    if (!reset) begin
      m_ptr = 0; m_ovf = 0; m_err = 0; m_err_addr = 0; e_instr = 0; e_data = 0;
      return;
    end
    iok = addr_ok(instr_addr);
    dok = addr_ok(data_addr);
    pre = load_en && !m_ovf;
    if (pre) m_mem[m_ptr] = load_data;
    else if (!data_rd_wr && dok) m_mem[widx(data_addr)] = data_out;
    e_instr = iok ? m_read(widx(instr_addr)) : BAD;
    e_data  = !data_rd_wr ? data_out : (dok ? m_read(widx(data_addr)) : BAD);
    if ((!iok || !dok) && !m_err) m_err_addr = !dok ? data_addr : instr_addr;
    if (!iok || !dok) m_err = 1;
    if (pre) begin
      if (m_ptr == DEPTH - 1) m_ovf = 1;
      else m_ptr++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    reset = 0;
    tick(); tick();
    n_vec++; if (instr_in !== e_instr) begin n_err++; $display("FAIL reset_instr_in got %h exp %h", instr_in, e_instr); end
    n_vec++; if (data_in !== e_data) begin n_err++; $display("FAIL reset_data_in got %h exp %h", data_in, e_data); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset_mem_err got %b exp 0", mem_err); end
    n_vec++; if (err_addr !== 32'h0) begin n_err++; $display("FAIL reset_err_addr got %h exp 0", err_addr); end
    n_vec++; if (load_ovf !== 1'b0) begin n_err++; $display("FAIL reset_load_ovf got %b exp 0", load_ovf); end
    reset = 1;
  endtask

  task automatic test_preload();
    logic [31:0] words [3];
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333;
    instr_addr = 32'h8002_0004;
    for (int i = 0; i < 3; i++) begin
      load_en = 1; load_data = words[i];
      tick();
    end
    load_en = 0;
    tick();
    n_vec++; if (instr_in !== 32'h2222_2222) begin n_err++; $display("FAIL preload_fetch got %h exp 22222222", instr_in); end
    n_vec++; if (load_ovf !== 1'b0) begin n_err++; $display("FAIL preload_ovf got %b exp 0", load_ovf); end
    instr_addr = BASE;
  endtask

  task automatic test_write_read();
    data_addr = 32'h8011_FFFC; data_out = 32'hCAFE_F00D; data_rd_wr = 0;
    tick();
    n_vec++; if (data_in !== 32'hCAFE_F00D) begin n_err++; $display("FAIL wr_echo got %h exp cafef00d", data_in); end
    data_rd_wr = 1; data_out = 32'h0;
    tick();
    n_vec++; if (data_in !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rd_last_word got %h exp cafef00d", data_in); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rd_last_word_err got %b exp 0", mem_err); end
  endtask

  task automatic test_collision();
    instr_addr = 32'h8002_0008; data_addr = 32'h8002_0008;
    data_out = 32'hA5A5_A5A5; data_rd_wr = 0;
    tick();
    n_vec++; if (instr_in !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL collision got %h exp a5a5a5a5", instr_in); end
    data_rd_wr = 1; instr_addr = BASE;
  endtask

  task automatic test_random();
    instr_addr = BASE;
    for (int i = 0; i < 16; i++) begin
      data_addr = BASE + 32'(4 * i); data_out = $urandom; data_rd_wr = 0;
      tick();
    end
    for (int n = 0; n < 300; n++) begin
      instr_addr = BASE + 32'(4 * $urandom_range(0, 15));
      data_addr  = BASE + 32'(4 * $urandom_range(0, 15));
      data_rd_wr = 1'($urandom_range(0, 1));
      data_out   = $urandom;
      load_en    = ($urandom_range(0, 7) == 0);
      load_data  = $urandom;
      tick();
      n_vec++; if (instr_in !== e_instr) begin n_err++; $display("FAIL rand_instr[%0d] got %h exp %h", n, instr_in, e_instr); end
      n_vec++; if (data_in !== e_data) begin n_err++; $display("FAIL rand_data[%0d] got %h exp %h", n, data_in, e_data); end
      n_vec++; if (mem_err !== m_err) begin n_err++; $display("FAIL rand_err[%0d] got %b exp %b", n, mem_err, m_err); end
    end
    load_en = 0; data_rd_wr = 1; instr_addr = BASE; data_addr = BASE;
    tick();
  endtask

  task automatic test_faults();
    data_rd_wr = 1; data_addr = 32'h8002_0002;
    tick();
    n_vec++; if (data_in !== BAD) begin n_err++; $display("FAIL misalign_rd got %h exp deadbeef", data_in); end
    n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL misalign_err got %b exp 1", mem_err); end
    n_vec++; if (err_addr !== 32'h8002_0002) begin n_err++; $display("FAIL misalign_addr got %h exp 80020002", err_addr); end
    data_addr = 32'h7FFF_FFFC; data_rd_wr = 0; data_out = $urandom;
    tick();
    n_vec++; if (err_addr !== 32'h8002_0002) begin n_err++; $display("FAIL below_base_addr got %h exp 80020002", err_addr); end
    data_addr = 32'h8012_0000; data_rd_wr = 1;
    tick();
    n_vec++; if (data_in !== BAD) begin n_err++; $display("FAIL past_end_rd got %h exp deadbeef", data_in); end
    n_vec++; if (err_addr !== m_err_addr) begin n_err++; $display("FAIL past_end_addr got %h exp %h", err_addr, m_err_addr); end
    data_addr = BASE;
  endtask

  task automatic test_mid_reset();
    instr_addr = BASE; data_addr = BASE; data_rd_wr = 1;
    reset = 0; load_en = 0;
    tick();
    reset = 1; load_en = 1; load_data = 32'h1234_5678;
    tick();
    reset = 0; load_data = 32'hBBBB_BBBB;
    tick();
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL midrst_err got %b exp 0", mem_err); end
    n_vec++; if (err_addr !== 32'h0) begin n_err++; $display("FAIL midrst_err_addr got %h exp 0", err_addr); end
    n_vec++; if (instr_in !== 32'h0) begin n_err++; $display("FAIL midrst_instr got %h exp 0", instr_in); end
    n_vec++; if (data_in !== 32'h0) begin n_err++; $display("FAIL midrst_data got %h exp 0", data_in); end
    reset = 1; load_data = 32'h7777_7777;
    tick();
    load_en = 0;
    tick();
    n_vec++; if (instr_in !== 32'h7777_7777) begin n_err++; $display("FAIL midrst_idx0 got %h exp 77777777", instr_in); end
    instr_addr = BASE + 32'd4;
    tick();
    n_vec++; if (instr_in !== e_instr || instr_in === 32'hBBBB_BBBB) begin n_err++; $display("FAIL midrst_idx1 got %h exp %h", instr_in, e_instr); end
    instr_addr = BASE;
  endtask

  task automatic test_dual_fault();
    instr_addr = 32'h8002_0001; data_addr = 32'h9000_0000; data_rd_wr = 1;
    tick();
    n_vec++; if (err_addr !== 32'h9000_0000) begin n_err++; $display("FAIL dual_addr got %h exp 90000000", err_addr); end
    n_vec++; if (instr_in !== BAD) begin n_err++; $display("FAIL dual_instr got %h exp deadbeef", instr_in); end
    n_vec++; if (data_in !== BAD) begin n_err++; $display("FAIL dual_data got %h exp deadbeef", data_in); end
    instr_addr = BASE; data_addr = BASE;
  endtask

  task automatic test_overflow();
    s_reset = 0;
    tick();
    s_reset = 1;
    for (int i = 0; i < 6; i++) begin
      s_load_en = 1; s_load_data = 32'h5000_0000 + 32'(i);
      tick();
      n_vec++; if (s_load_ovf !== (i >= 3)) begin n_err++; $display("FAIL ovf[%0d] got %b exp %b", i, s_load_ovf, (i >= 3)); end
    end
    s_load_en = 0; s_instr_addr = BASE;
    tick();
    n_vec++; if (s_instr_in !== 32'h5000_0000) begin n_err++; $display("FAIL ovf_idx0 got %h exp 50000000", s_instr_in); end
    s_instr_addr = BASE + 32'd12;
    tick();
    n_vec++; if (s_instr_in !== 32'h5000_0003) begin n_err++; $display("FAIL ovf_idx3 got %h exp 50000003", s_instr_in); end
    n_vec++; if (s_mem_err !== 1'b0) begin n_err++; $display("FAIL ovf_err got %b exp 0", s_mem_err); end
    s_instr_addr = BASE + 32'd16;
    tick();
    n_vec++; if (s_instr_in !== BAD) begin n_err++; $display("FAIL small_oob got %h exp deadbeef", s_instr_in); end
    n_vec++; if (s_err_addr !== BASE + 32'd16) begin n_err++; $display("FAIL small_oob_addr got %h exp %h", s_err_addr, BASE + 32'd16); end
  endtask

  initial begin
    reset = 0; instr_addr = BASE; data_addr = BASE; data_out = 0;
    data_rd_wr = 1; load_en = 0; load_data = 0;
    s_reset = 0; s_instr_addr = BASE; s_data_addr = BASE; s_data_out = 0;
    s_data_rd_wr = 1; s_load_en = 0; s_load_data = 0;
    m_ptr = 0; m_ovf = 0; m_err = 0; m_err_addr = 0; e_instr = 0; e_data = 0;

    test_reset();
    test_preload();
    test_write_read();
    test_collision();
    test_random();
    test_faults();
    test_mid_reset();
    test_dual_fault();
    test_overflow();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mips_mem
`default_nettype wire
